// File: rtl/sp_load_arbiter.sv
// Round-robin arbiter sharing the scratchpad write bus between the IF and filter loaders.
// Optional SP_ARB_FIXED_PRIO_EN: when both channels are eligible the filter is always granted first.
module sp_load_arbiter #(
    parameter int DW        = 16,
    parameter int AW        = 6,
    parameter int IF_DEPTH  = 64,
    parameter int FLT_DEPTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          if_valid_i,
    input  logic [DW-1:0] if_data_i,
    input  logic          if_last_i,
    output logic          if_ready_o,
    input  logic          flt_valid_i,
    input  logic [DW-1:0] flt_data_i,
    input  logic          flt_last_i,
    output logic          flt_ready_o,
    output logic          wr_en_o,
    output logic          wr_sel_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [DW-1:0] wr_data_o,
    output logic          done1_o,
    output logic          done2_o,
    output logic          if_full_o,
    output logic          filter_full_o,
    output logic          busy_o
);
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_GNT_IF, S_GNT_FLT, S_END} state_e;

    localparam logic [AW:0] IF_LIM  = (AW+1)'(IF_DEPTH);
    localparam logic [AW:0] FLT_LIM = (AW+1)'(FLT_DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   if_cnt_q, if_cnt_d, flt_cnt_q, flt_cnt_d;
    logic          done1_q, done1_d, done2_q, done2_d;
    logic          if_full_q, if_full_d, flt_full_q, flt_full_d;
    logic          wr_en_q, wr_en_d, wr_sel_q, wr_sel_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          if_at_lim, flt_at_lim, if_hs, flt_hs, if_el, flt_el;
`ifndef SP_ARB_FIXED_PRIO_EN
    logic          rr_q, rr_d;
`endif

    assign if_at_lim  = (if_cnt_q == IF_LIM);
    assign flt_at_lim = (flt_cnt_q == FLT_LIM);

    // Ready is withheld during an aborting start so no word is lost to the cleared counters.
    assign if_ready_o  = (state_q == S_GNT_IF)  && !if_full_q  && !if_at_lim  && !start_i;
    assign flt_ready_o = (state_q == S_GNT_FLT) && !flt_full_q && !flt_at_lim && !start_i;
    assign if_hs  = if_valid_i  && if_ready_o;
    assign flt_hs = flt_valid_i && flt_ready_o;
    assign if_el  = if_valid_i  && !done1_q && !if_full_q;
    assign flt_el = flt_valid_i && !done2_q && !flt_full_q;

    assign busy_o        = (state_q != S_IDLE);
    assign wr_en_o       = wr_en_q;
    assign wr_sel_o      = wr_sel_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign done1_o       = done1_q;
    assign done2_o       = done2_q;
    assign if_full_o     = if_full_q;
    assign filter_full_o = flt_full_q;

    always_comb begin
        state_d    = state_q;
        if_cnt_d   = if_cnt_q;
        flt_cnt_d  = flt_cnt_q;
        done1_d    = done1_q;
        done2_d    = done2_q;
        if_full_d  = if_full_q;
        flt_full_d = flt_full_q;
        wr_en_d    = 1'b0;
        wr_sel_d   = wr_sel_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifndef SP_ARB_FIXED_PRIO_EN
        rr_d       = rr_q;
`endif
        if (if_hs) begin
            wr_en_d   = 1'b1;
            wr_sel_d  = 1'b0;
            wr_addr_d = if_cnt_q[AW-1:0];
            wr_data_d = if_data_i;
            if_cnt_d  = if_cnt_q + 1'b1;
        end
        if (flt_hs) begin
            wr_en_d   = 1'b1;
            wr_sel_d  = 1'b1;
            wr_addr_d = flt_cnt_q[AW-1:0];
            wr_data_d = flt_data_i;
            flt_cnt_d = flt_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: if (start_i) state_d = S_ARB;
            S_ARB: begin
                if ((done1_q && done2_q) || if_full_q || flt_full_q) state_d = S_END;
`ifdef SP_ARB_FIXED_PRIO_EN
                else if (if_el && flt_el) state_d = S_GNT_FLT;
`else
                else if (if_el && flt_el) begin
                    state_d = rr_q ? S_GNT_FLT : S_GNT_IF;
                    rr_d    = !rr_q;
                end
`endif
                else if (if_el)  state_d = S_GNT_IF;
                else if (flt_el) state_d = S_GNT_FLT;
            end
            S_GNT_IF: begin
                if (if_valid_i && if_at_lim) begin
                    if_full_d = 1'b1;
                    state_d   = S_END;
                end else if (if_hs && if_last_i) begin
                    done1_d = 1'b1;
                    state_d = done2_q ? S_END : S_ARB;
                end
            end
            S_GNT_FLT: begin
                if (flt_valid_i && flt_at_lim) begin
                    flt_full_d = 1'b1;
                    state_d    = S_END;
                end else if (flt_hs && flt_last_i) begin
                    done2_d = 1'b1;
                    state_d = done1_q ? S_END : S_ARB;
                end
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (start_i) begin
            state_d    = S_ARB;
            if_cnt_d   = '0;
            flt_cnt_d  = '0;
            done1_d    = 1'b0;
            done2_d    = 1'b0;
            if_full_d  = 1'b0;
            flt_full_d = 1'b0;
`ifndef SP_ARB_FIXED_PRIO_EN
            rr_d       = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            if_cnt_q   <= '0;
            flt_cnt_q  <= '0;
            done1_q    <= 1'b0;
            done2_q    <= 1'b0;
            if_full_q  <= 1'b0;
            flt_full_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            if_cnt_q   <= if_cnt_d;
            flt_cnt_q  <= flt_cnt_d;
            done1_q    <= done1_d;
            done2_q    <= done2_d;
            if_full_q  <= if_full_d;
            flt_full_q <= flt_full_d;
            wr_en_q    <= wr_en_d;
            wr_sel_q   <= wr_sel_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

`ifndef SP_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_q <= 1'b0;
        else         rr_q <= rr_d;
    end
`endif
endmodule

// File: tb/tb_sp_load_arbiter.sv
// Scoreboard bench for sp_load_arbiter: random streams, expected writes queued from a
// stream-level model, popped by an independent write monitor.
module tb_sp_load_arbiter;
    localparam int DW = 16, AW = 6, IF_DEPTH = 64, FLT_DEPTH = 32;
`ifdef SP_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic          if_valid = 1'b0, if_last = 1'b0, flt_valid = 1'b0, flt_last = 1'b0;
    logic [DW-1:0] if_data = '0, flt_data = '0;
    logic          if_ready, flt_ready, wr_en, wr_sel, done1, done2, if_full, filter_full, busy;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          hs_prev;

    int tests = 0, fails = 0;

    typedef struct packed {
        logic          sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t           exp_q[$];
    logic [DW-1:0] if_words[$], flt_words[$];

    sp_load_arbiter #(.DW(DW), .AW(AW), .IF_DEPTH(IF_DEPTH), .FLT_DEPTH(FLT_DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .if_valid_i(if_valid), .if_data_i(if_data), .if_last_i(if_last), .if_ready_o(if_ready),
        .flt_valid_i(flt_valid), .flt_data_i(flt_data), .flt_last_i(flt_last), .flt_ready_o(flt_ready),
        .wr_en_o(wr_en), .wr_sel_o(wr_sel), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .done1_o(done1), .done2_o(done2), .if_full_o(if_full), .filter_full_o(filter_full),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) hs_prev <= 1'b0;
        else        hs_prev <= (if_valid && if_ready) || (flt_valid && flt_ready);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {1'b0, wr_en, wr_sel, wr_addr, wr_data, done1, done2, if_full, filter_full,
                busy, if_ready, flt_ready};
    endfunction

    // Write monitor: every strobe must follow a handshake by one cycle and match the queue head.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (hs_prev || wr_en) chk("wr_latency", {31'd0, wr_en}, {31'd0, hs_prev});
                if (wr_en) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_write: sel %0d addr %0d data %0h, none expected",
                                 wr_sel, wr_addr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_sel",  {31'd0, wr_sel}, {31'd0, e.sel});
                        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                        chk("wr_data", 32'(wr_data), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic set_in(input bit ch, input logic v, input logic [DW-1:0] d, input logic l);
        if (ch) begin flt_valid = v; flt_data = d; flt_last = l; end
        else    begin if_valid  = v; if_data  = d; if_last  = l; end
    endtask

    task automatic gen_words(input bit ch, input int n, input int base);
        logic [DW-1:0] w;
        if (ch) flt_words.delete(); else if_words.delete();
        for (int i = 0; i < n; i++) begin
            w = (base != 0) ? DW'(base + i) : DW'($urandom);
            if (ch) flt_words.push_back(w); else if_words.push_back(w);
        end
    endtask

    task automatic push_exp(input bit ch, input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.sel  = ch;
            e.addr = AW'(i);
            e.data = ch ? flt_words[i] : if_words[i];
            exp_q.push_back(e);
        end
    endtask

    // Offers words on one channel; returns how many were accepted within the cycle budget.
    task automatic drive(input bit ch, input int n, input bit with_last, input int gap_pct,
                         input int limit, output int acc);
        int   cyc  = 0;
        int   hold = 0;
        logic rdy;
        acc = 0;
        while (acc < n && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (hold > 0) begin
                hold--;
                set_in(ch, 1'b0, '0, 1'b0);
            end else begin
                set_in(ch, 1'b1, ch ? flt_words[acc] : if_words[acc], with_last && (acc == n - 1));
                #1 rdy = ch ? flt_ready : if_ready;
                if (rdy) begin
                    acc++;
                    if ($urandom_range(99) < gap_pct) hold = $urandom_range(3, 1);
                end
            end
        end
        @(negedge clk);
        set_in(ch, 1'b0, '0, 1'b0);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // One load phase: model outcome from stream lengths, queue expected writes, run both loaders.
    task automatic run_pair(input string tag, input int n_if, input bit l_if, input int n_flt,
                            input bit l_flt, input int gap, input int base_if, input int limit);
        int a_if = 0, a_flt = 0, e_if, e_flt;
        bit d1, d2, f1, f2;
        f1 = n_if > IF_DEPTH;    e_if  = f1 ? IF_DEPTH  : n_if;  d1 = l_if  && !f1;
        f2 = n_flt > FLT_DEPTH;  e_flt = f2 ? FLT_DEPTH : n_flt; d2 = l_flt && !f2;
        gen_words(1'b0, n_if, base_if);
        gen_words(1'b1, n_flt, 0);
        if (FIXED) begin push_exp(1'b1, e_flt); push_exp(1'b0, e_if); end
        else       begin push_exp(1'b0, e_if);  push_exp(1'b1, e_flt); end
        pulse_start();
        fork
            begin if (n_if  > 0) drive(1'b0, n_if,  l_if,  gap, limit, a_if);  end
            begin if (n_flt > 0) drive(1'b1, n_flt, l_flt, gap, limit, a_flt); end
        join
        repeat (3) @(negedge clk);
        chk({tag, ".if_accepted"},  a_if,  e_if);
        chk({tag, ".flt_accepted"}, a_flt, e_flt);
        chk({tag, ".done1"},       {31'd0, done1},       {31'd0, d1});
        chk({tag, ".done2"},       {31'd0, done2},       {31'd0, d2});
        chk({tag, ".if_full"},     {31'd0, if_full},     {31'd0, f1});
        chk({tag, ".filter_full"}, {31'd0, filter_full}, {31'd0, f2});
        chk({tag, ".busy"},        {31'd0, busy},        {31'd0, !((d1 && d2) || f1 || f2)});
        chk({tag, ".sb_empty"},    exp_q.size(), 0);
    endtask

    initial begin
        int acc;
        #2 rst_n = 1'b0;
        #1 chk("reset_outputs", outs(), 0);
        @(negedge clk); rst_n = 1'b1;

        // Reset asserted mid-burst clears everything at once.
        pulse_start();
        gen_words(1'b0, 3, 'h0a01);
        push_exp(1'b0, 3);
        drive(1'b0, 3, 1'b0, 0, 100, acc);
        #2 rst_n = 1'b0;
        #1 chk("reset_midburst", outs(), 0);
        @(negedge clk); rst_n = 1'b1;
        chk("reset_sb_empty", exp_q.size(), 0);
        run_pair("after_reset", 3, 1'b1, 0, 1'b0, 0, 0, 200);

        run_pair("if_only", 4, 1'b1, 0, 1'b0, 0, 'h11, 200);

        // start while waiting in ARB re-arms the sticky flags.
        pulse_start();
        chk("rearm.done1", {31'd0, done1}, 0);
        chk("rearm.busy",  {31'd0, busy},  1);

        run_pair("both_2", 2, 1'b1, 2, 1'b1, 0, 0, 200);
        run_pair("flt_overflow", 0, 1'b0, FLT_DEPTH + 1, 1'b0, 0, 0, 80);
        run_pair("if_exact", IF_DEPTH, 1'b1, 0, 1'b0, 20, 0, 600);

        // Abort mid-burst; the next word restarts at address 0 without a fresh start.
        pulse_start();
        gen_words(1'b0, 3, 0);
        push_exp(1'b0, 3);
        drive(1'b0, 3, 1'b0, 0, 100, acc);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("abort.accepted", acc, 3);
        chk("abort.done1", {31'd0, done1}, 0);
        gen_words(1'b0, 4, 0);
        push_exp(1'b0, 4);
        drive(1'b0, 4, 1'b1, 0, 100, acc);
        repeat (2) @(negedge clk);
        chk("abort.accepted2", acc, 4);
        chk("abort.done1_set", {31'd0, done1}, 1);
        chk("abort.sb_empty", exp_q.size(), 0);

        for (int i = 0; i < 5; i++)
            run_pair("random", $urandom_range(IF_DEPTH, 1), 1'b1, $urandom_range(FLT_DEPTH, 1),
                     1'b1, 30, 0, 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
